// File: rtl/pacman_sprite_render.sv
// pacman_sprite_render
//   Overlays a 16x16 Pac-Man sprite onto the background pixel stream of a
//   640x480 VGA timing stage. Position/direction updates are offered through
//   a valid/ready handshake into a shadow register and only become active on
//   frame_start, so the sprite never tears mid-frame. The mouth animates
//   CLOSED->HALF->OPEN->HALF2 once every 8 frames.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   x, y                current pixel column/row from the timing stage
//   frame_start         one-cycle pulse at start of vertical blank
//   bg_color            RGB332 background colour for (x,y)
//   pos_valid/pos_ready offer handshake for pos_x, pos_y, pos_dir
//   pos_dir             0 right, 1 left, 2 up, 3 down
//   color               RGB332 output pixel, 2 cycles after (x,y,bg_color)
module pacman_sprite_render #(
    parameter logic [7:0] SPR_COLOR = 8'b11111100,
    parameter logic [9:0] INIT_X    = 10'd312,
    parameter logic [8:0] INIT_Y    = 9'd232
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       frame_start,
    input  logic [7:0] bg_color,
    input  logic       pos_valid,
    input  logic [9:0] pos_x,
    input  logic [8:0] pos_y,
    input  logic [1:0] pos_dir,
    output logic       pos_ready,
    output logic [7:0] color
);

    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        HALF   = 2'd1,
        OPEN   = 2'd2,
        HALF2  = 2'd3
    } mouth_t;

    logic [9:0] act_x;
    logic [8:0] act_y;
    logic [1:0] act_dir;
    logic [9:0] sh_x;
    logic [8:0] sh_y;
    logic [1:0] sh_dir;
    logic [2:0] frame_cnt;
    mouth_t     mouth;

    // Shadow register, active position and mouth animation.
    // pos_ready low means the shadow holds an update waiting for frame_start.
    // An offer accepted on a frame_start cycle finds pos_ready high there, so
    // it is not copied until the following frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_x     <= INIT_X;
            act_y     <= INIT_Y;
            act_dir   <= 2'd0;
            sh_x      <= '0;
            sh_y      <= '0;
            sh_dir    <= '0;
            pos_ready <= 1'b1;
            frame_cnt <= '0;
            mouth     <= CLOSED;
        end else begin
            if (pos_valid && pos_ready) begin
                sh_x      <= pos_x;
                sh_y      <= pos_y;
                sh_dir    <= pos_dir;
                pos_ready <= 1'b0;
            end
            if (frame_start) begin
                if (!pos_ready) begin
                    act_x     <= sh_x;
                    act_y     <= sh_y;
                    act_dir   <= sh_dir;
                    pos_ready <= 1'b1;
                end
                frame_cnt <= frame_cnt + 3'd1;
                if (frame_cnt == 3'd7) begin
                    case (mouth)
                        CLOSED:  mouth <= HALF;
                        HALF:    mouth <= OPEN;
                        OPEN:    mouth <= HALF2;
                        default: mouth <= CLOSED;
                    endcase
                end
            end
        end
    end

    // Stage 1: offsets into the sprite box and rotation by direction.
    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_box;
    logic        visible;
    logic [3:0]  u1;
    logic [3:0]  v1;

    always_comb begin
        dx      = {1'b0, x} - {1'b0, act_x};
        dy      = {1'b0, y} - {2'b00, act_y};
        // Upper bits all zero means 0..15; negative offsets have the sign bit set.
        in_box  = (dx[10:4] == '0) && (dy[10:4] == '0);
        visible = (x < 10'd640) && (y < 10'd480);
        u1      = dx[3:0];
        v1      = dy[3:0];
        case (act_dir)
            2'd1: begin
                u1 = 4'd15 - dx[3:0];
                v1 = dy[3:0];
            end
            2'd2: begin
                u1 = 4'd15 - dy[3:0];
                v1 = dx[3:0];
            end
            2'd3: begin
                u1 = dy[3:0];
                v1 = dx[3:0];
            end
            default: begin
                u1 = dx[3:0];
                v1 = dy[3:0];
            end
        endcase
    end

    logic [3:0] s1_u;
    logic [3:0] s1_v;
    logic       s1_in;
    logic       s1_vis;
    logic [7:0] s1_bg;
    mouth_t     s1_mouth;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_u     <= '0;
            s1_v     <= '0;
            s1_in    <= 1'b0;
            s1_vis   <= 1'b0;
            s1_bg    <= '0;
            s1_mouth <= CLOSED;
        end else begin
            s1_u     <= u1;
            s1_v     <= v1;
            s1_in    <= in_box;
            s1_vis   <= visible;
            s1_bg    <= bg_color;
            s1_mouth <= mouth;
        end
    end

    // Stage 2: disc test, mouth wedge and colour select.
    // |2u-15| and |2v-15| are odd 1..15; squares summed stay below 512.
    logic [4:0] a_mag;
    logic [4:0] b_mag;
    logic [8:0] a9;
    logic [8:0] b9;
    logic [8:0] r2;
    logic       body;
    logic       mouth_hit;
    logic [7:0] color_next;

    always_comb begin
        a_mag = s1_u[3] ? ({s1_u, 1'b0} - 5'd15) : (5'd15 - {s1_u, 1'b0});
        b_mag = s1_v[3] ? ({s1_v, 1'b0} - 5'd15) : (5'd15 - {s1_v, 1'b0});
        a9    = {4'b0000, a_mag};
        b9    = {4'b0000, b_mag};
        r2    = a9 * a9 + b9 * b9;
        body  = (r2 <= 9'd225);
        mouth_hit = 1'b0;
        if (s1_u[3]) begin
            case (s1_mouth)
                HALF, HALF2: mouth_hit = ({b_mag, 1'b0} < {1'b0, a_mag});
                OPEN:        mouth_hit = (b_mag < a_mag);
                default:     mouth_hit = 1'b0;
            endcase
        end
        if (!s1_vis) begin
            color_next = 8'h00;
        end else if (s1_in && body && !mouth_hit) begin
            color_next = SPR_COLOR;
        end else begin
            color_next = s1_bg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color <= 8'h00;
        end else begin
            color <= color_next;
        end
    end

endmodule

// File: tb/tb_pacman_sprite_render.sv
// tb_pacman_sprite_render
//   Scoreboard bench for pacman_sprite_render: the stimulus side pushes the
//   expected pixel for every cycle into a queue, a monitor pops and compares
//   against color, and also checks pos_ready against the reference model.
module tb_pacman_sprite_render;

    localparam logic [7:0] SPR   = 8'hFC;
    localparam int         IX    = 312;
    localparam int         IY    = 232;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       frame_start = 1'b0;
    logic [7:0] bg_color = '0;
    logic       pos_valid = 1'b0;
    logic [9:0] pos_x = '0;
    logic [8:0] pos_y = '0;
    logic [1:0] pos_dir = '0;
    logic       pos_ready;
    logic [7:0] color;

    pacman_sprite_render #(
        .SPR_COLOR(8'b11111100),
        .INIT_X   (10'd312),
        .INIT_Y   (9'd232)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .y          (y),
        .frame_start(frame_start),
        .bg_color   (bg_color),
        .pos_valid  (pos_valid),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_dir    (pos_dir),
        .pos_ready  (pos_ready),
        .color      (color)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (mouth: 0 closed, 1 half, 2 open, 3 half2)
    int m_ax, m_ay, m_dir, m_mouth, m_frames, m_pend, m_sx, m_sy, m_sd;
    logic [7:0] exp_q[$];
    string      name_q[$];
    int         force_exp = -1;
    string      vec_name = "idle";

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Pixel rule straight from geometry: disc of radius 7.5 centred in a
    // 16x16 box, with a wedge cut out on the facing side.
    function automatic logic [7:0] ref_pix(input int ax, input int ay, input int dir,
                                           input int mth, input int px, input int py,
                                           input logic [7:0] bg);
        int dx, dy, u, v, a, b;
        if (px >= 640 || py >= 480) return 8'h00;
        dx = px - ax;
        dy = py - ay;
        if (dx < 0 || dx > 15 || dy < 0 || dy > 15) return bg;
        case (dir)
            0: begin u = dx;      v = dy; end
            1: begin u = 15 - dx; v = dy; end
            2: begin u = 15 - dy; v = dx; end
            default: begin u = dy; v = dx; end
        endcase
        a = 2 * u - 15;
        b = 2 * v - 15;
        if (a * a + b * b > 225) return bg;
        if (b < 0) b = -b;
        if (u >= 8) begin
            if ((mth == 1 || mth == 3) && 2 * b < a) return bg;
            if (mth == 2 && b < a) return bg;
        end
        return SPR;
    endfunction

    task automatic m_reset();
        m_ax = IX; m_ay = IY; m_dir = 0; m_mouth = 0; m_frames = 0;
        m_pend = 0; m_sx = 0; m_sy = 0; m_sd = 0;
        exp_q.delete();
        name_q.delete();
    endtask

    // Model: expected pixel uses the state in force before this edge,
    // then the handshake/frame rules update the model.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) begin
                int acc, cp;
                if (force_exp >= 0) exp_q.push_back(force_exp[7:0]);
                else exp_q.push_back(ref_pix(m_ax, m_ay, m_dir, m_mouth, int'(x), int'(y), bg_color));
                name_q.push_back(vec_name);
                acc = (pos_valid && m_pend == 0) ? 1 : 0;
                cp  = (frame_start && m_pend == 1) ? 1 : 0;
                if (cp == 1) begin
                    m_ax = m_sx; m_ay = m_sy; m_dir = m_sd; m_pend = 0;
                end
                if (acc == 1) begin
                    m_sx = int'(pos_x); m_sy = int'(pos_y); m_sd = int'(pos_dir); m_pend = 1;
                end
                if (frame_start) begin
                    m_frames++;
                    if (m_frames % 8 == 0) m_mouth = (m_mouth + 1) % 4;
                end
            end
        end
    end

    // Monitor: output for the edge before last is compared each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("pos_ready", {7'b0, pos_ready}, (m_pend == 0) ? 8'h01 : 8'h00);
                if (exp_q.size() >= 2) begin
                    logic [7:0] e;
                    string nm;
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    check({"color ", nm}, color, e);
                end
            end
        end
    end

    task automatic cyc(input int xx, input int yy, input logic [7:0] bg, input logic fs,
                       input logic pv, input int px, input int py, input int pd,
                       input int fexp, input string nm);
        @(negedge clk);
        x = xx[9:0]; y = yy[9:0]; bg_color = bg; frame_start = fs;
        pos_valid = pv; pos_x = px[9:0]; pos_y = py[8:0]; pos_dir = pd[1:0];
        force_exp = fexp; vec_name = nm;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(700, 500, 8'h00, 0, 0, 0, 0, 0, -1, "idle");
    endtask

    initial begin
        m_reset();
        // Power-on reset
        repeat (3) begin
            @(negedge clk);
            check("reset color", color, 8'h00);
            check("reset pos_ready", {7'b0, pos_ready}, 8'h01);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Centre of the default sprite vs. a pixel left of it
        cyc(320, 240, 8'h03, 0, 0, 0, 0, 0, 8'hFC, "centre");
        cyc(300, 240, 8'h03, 0, 0, 0, 0, 0, 8'h03, "left_of_box");

        // 16 frames -> OPEN; wedge pixel right-facing is background,
        // left-facing the same pixel lies in the body on the closed side
        for (int i = 0; i < 16; i++) cyc(700, 500, 8'h00, 1, 0, 0, 0, 0, -1, "frames");
        cyc(IX + 14, IY + 7, 8'h5A, 0, 0, 0, 0, 0, 8'h5A, "open_right");
        cyc(IX + 1, IY + 7, 8'h5A, 0, 0, 0, 0, 0, 8'hFC, "open_right_back");
        cyc(700, 500, 8'h00, 0, 1, IX, IY, 1, -1, "offer_left");
        cyc(700, 500, 8'h00, 1, 0, 0, 0, 0, -1, "apply_left");
        cyc(IX + 14, IY + 7, 8'h5A, 0, 0, 0, 0, 0, 8'hFC, "open_left");

        // Offer not applied until frame_start
        cyc(700, 500, 8'h00, 0, 1, 100, 50, 0, -1, "offer_100_50");
        cyc(107, 57, 8'h55, 0, 0, 0, 0, 0, 8'h55, "before_frame");
        cyc(107, 57, 8'h55, 1, 0, 0, 0, 0, 8'h55, "frame_cycle");
        cyc(107, 57, 8'h55, 0, 0, 0, 0, 0, 8'hFC, "after_frame");

        // Offer on the frame_start cycle waits one more frame
        cyc(700, 500, 8'h00, 1, 1, 200, 100, 0, -1, "offer_on_frame");
        cyc(207, 107, 8'h11, 0, 0, 0, 0, 0, 8'h11, "not_yet");
        cyc(207, 107, 8'h11, 1, 0, 0, 0, 0, 8'h11, "next_frame");
        cyc(207, 107, 8'h11, 0, 0, 0, 0, 0, 8'hFC, "applied");

        // Right screen edge: no wrap, blanking forces black
        cyc(700, 500, 8'h00, 0, 1, 632, 0, 0, -1, "offer_edge");
        cyc(700, 500, 8'h00, 1, 0, 0, 0, 0, -1, "apply_edge");
        cyc(639, 7, 8'h22, 0, 0, 0, 0, 0, 8'hFC, "edge_in");
        cyc(0, 7, 8'h22, 0, 0, 0, 0, 0, 8'h22, "edge_nowrap");
        cyc(640, 7, 8'h22, 0, 0, 0, 0, 0, 8'h00, "edge_blank");
        cyc(5, 480, 8'h22, 0, 0, 0, 0, 0, 8'h00, "bottom_blank");

        // Reset with an update pending
        cyc(700, 500, 8'h00, 0, 1, 50, 60, 2, -1, "offer_pending");
        idle(1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("midreset pos_ready", {7'b0, pos_ready}, 8'h01);
        check("midreset color", color, 8'h00);
        @(negedge clk);
        check("hold color", color, 8'h00);
        x = 10'd320; y = 10'd240; bg_color = 8'h03; frame_start = 1'b0; pos_valid = 1'b0;
        force_exp = 8'hFC; vec_name = "post_reset_centre";
        @(negedge clk);
        check("release color0", color, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("release color1", color, 8'h00);
        cyc(IX + 14, IY + 7, 8'h5A, 0, 0, 0, 0, 0, 8'hFC, "post_reset_closed");
        cyc(IX + 1, IY + 1, 8'h5A, 0, 0, 0, 0, 0, 8'h5A, "post_reset_corner");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int xx, yy, px, py;
            logic fs, pv;
            if ($urandom_range(0, 3) != 0) begin
                xx = m_ax + int'($urandom_range(0, 21)) - 3;
                yy = m_ay + int'($urandom_range(0, 21)) - 3;
                if (xx < 0) xx = 0;
                if (yy < 0) yy = 0;
                if (xx > 1023) xx = 1023;
                if (yy > 1023) yy = 1023;
            end else begin
                xx = int'($urandom_range(0, 1023));
                yy = int'($urandom_range(0, 1023));
            end
            fs = ($urandom_range(0, 15) == 0);
            pv = ($urandom_range(0, 2) == 0);
            px = ($urandom_range(0, 7) == 0) ? int'($urandom_range(600, 1023))
                                             : int'($urandom_range(0, 639));
            py = int'($urandom_range(0, 511));
            cyc(xx, yy, 8'($urandom), fs, pv, px, py, int'($urandom_range(0, 3)), -1, "random");
        end

        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
